mul256_seq: RTL and testbench

Sequential 256x256-bit unsigned multiplier serving the multiplier port used by the Ed25519 signing reduction logic: the requester drives a start pulse with two operands, and this block returns a 512-bit product with a one-cycle done pulse. The multiplier operand is consumed one digit per cycle, least significant digit first. Leading all-zero digits of the multiplier are skipped, so short operands such as 4-bit constants finish in one digit cycle. The product is held stable until the next product completes, so the requester can sample it at any time before then.

---
 rtl/mul256_seq_pkg.sv | 25 ++
 rtl/mul256_seq_if.sv | 14 +
 rtl/mul256_seq_row.sv | 15 +
 rtl/mul256_seq.sv | 93 +++++++++
 tb/tb_mul256_seq.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mul256_seq_pkg.sv
// Shared constants, FSM encoding and multiplier-length helper for the
// 256x256 sequential multiplier.
package mul_pkg;

  localparam int OP_W        = 256;
  localparam int Q_W         = 512;
  localparam int DEF_DIGIT_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } mulState_t;

  // Digits needed to cover the highest set bit of b; an all-zero b still takes one digit.
  function automatic logic [15:0] numDigits(input logic [OP_W-1:0] b, input int digitW);
    logic [15:0] n;
    n = 16'd1;
    for (int i = 0; i < OP_W; i++) begin
      if (b[i]) n = 16'(i / digitW + 1);
    end
    return n;
  endfunction

endpackage

// File: rtl/mul256_seq_if.sv
// Start/operand/product bundle between a requester and mul256_seq.
interface mul256_seq_if;
  import mul_pkg::*;

  logic            iStart;
  logic [OP_W-1:0] iD0;
  logic [OP_W-1:0] iD1;
  logic            oDone;
  logic [Q_W-1:0]  oQ;
  logic            oBusy;

  modport master (output iStart, iD0, iD1, input  oDone, oQ, oBusy);
  modport slave  (input  iStart, iD0, iD1, output oDone, oQ, oBusy);
endinterface

// File: rtl/mul256_seq_row.sv
// Combinational 256 x DIGIT_W unsigned row multiplier; kept separate so it
// can be retimed or swapped for DSP-mapped logic without touching the FSM.
module mul_row_256xd
  import mul_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic [OP_W-1:0]         iA,
  input  logic [DIGIT_W-1:0]      iDigit,
  output logic [OP_W+DIGIT_W-1:0] oP
);
  localparam int P_W = OP_W + DIGIT_W;

  assign oP = P_W'(iA) * P_W'(iDigit);
endmodule

// File: rtl/mul256_seq.sv
// Digit-serial 256x256 multiplier: one multiplier digit per cycle, LSD first,
// leading zero digits skipped; product held until the next one completes.
module mul256_seq
  import mul_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W
) (
  input  logic          iClk,
  input  logic          iRstn,
  mul256_seq_if.slave   bus
);
  localparam int NDIG = OP_W / DIGIT_W;
  localparam int KW   = $clog2(NDIG) + 1;
  localparam int P_W  = OP_W + DIGIT_W;

  mulState_t       state;
  logic [OP_W-1:0] aReg;
  logic [OP_W-1:0] bReg;
  logic [Q_W-1:0]  accReg;
  logic [Q_W-1:0]  qReg;
  logic [KW-1:0]   kReg;
  logic [KW-1:0]   nReg;
  logic            doneReg;
  logic            busyReg;

  logic [DIGIT_W-1:0] digit;
  logic [P_W-1:0]     partial;
  logic [Q_W-1:0]     shifted;
  logic [Q_W-1:0]     sum;

  assign digit = DIGIT_W'(bReg >> (kReg * DIGIT_W));

  mul_row_256xd #(.DIGIT_W(DIGIT_W)) uRow (
    .iA     (aReg),
    .iDigit (digit),
    .oP     (partial)
  );

  // Bounded by A*B < 2^512, so the running sum never overflows.
  assign shifted = Q_W'(partial) << (kReg * DIGIT_W);
  assign sum     = accReg + shifted;

  always_ff @(posedge iClk) begin
    if (!iRstn) begin
      state   <= IDLE;
      aReg    <= '0;
      bReg    <= '0;
      accReg  <= '0;
      qReg    <= '0;
      kReg    <= '0;
      nReg    <= KW'(1);
      doneReg <= 1'b0;
      busyReg <= 1'b0;
    end else begin
      doneReg <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.iStart) begin
            aReg    <= bus.iD0;
            bReg    <= bus.iD1;
            accReg  <= '0;
            kReg    <= '0;
            nReg    <= KW'(numDigits(bus.iD1, DIGIT_W));
            busyReg <= 1'b1;
            state   <= MUL;
          end else begin
            busyReg <= 1'b0;
            state   <= IDLE;
          end
        end
        MUL: begin
          if (kReg == nReg - KW'(1)) begin
            qReg    <= sum;
            doneReg <= 1'b1;
            busyReg <= 1'b0;
            state   <= DONE;
          end else begin
            accReg <= sum;
            kReg   <= kReg + KW'(1);
          end
        end
        default: begin
          busyReg <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.oDone = doneReg;
  assign bus.oBusy = busyReg;
  assign bus.oQ    = qReg;
endmodule

// File: tb/tb_mul256_seq.sv
// Directed self-checking bench for mul256_seq with hand-derived products and latencies.
module tb_mul256_seq;
  logic clk;
  logic rstn;
  int   testsRun;
  int   testsFailed;

  mul256_seq_if bus ();

  mul256_seq #(.DIGIT_W(64)) dut (
    .iClk  (clk),
    .iRstn (rstn),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one start, then observes 12 cycles; lat = cycles from start sample to done.
  task automatic runOp(input logic [255:0] a, input logic [255:0] b,
                       output int lat, output int dones, output int dblDone);
    logic prevDone;
    bus.iD0 = a; bus.iD1 = b; bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    lat = -1; dones = 0; dblDone = 0; prevDone = bus.oDone;
    for (int c = 2; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bus.oDone) begin
        dones++;
        if (lat < 0) lat = c;
        if (prevDone) dblDone++;
      end
      prevDone = bus.oDone;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; bus.iStart = 1'b0; bus.iD0 = '0; bus.iD1 = '0;
    repeat (3) @(posedge clk);
    #1;
    testsRun++;
    if (bus.oQ !== 512'd0) begin testsFailed++; $display("FAIL reset_q got=%h exp=0", bus.oQ); end
    testsRun++;
    if (bus.oBusy !== 1'b0) begin testsFailed++; $display("FAIL reset_busy got=%b exp=0", bus.oBusy); end
    testsRun++;
    if (bus.oDone !== 1'b0) begin testsFailed++; $display("FAIL reset_done got=%b exp=0", bus.oDone); end
    rstn = 1'b1;
    @(posedge clk); #1;
    $display("[TB] reset: q=%0h busy=%b done=%b", bus.oQ, bus.oBusy, bus.oDone);
  endtask

  task automatic test_basic();
    logic [255:0] ones;
    logic [511:0] exp;
    int lat, dones, dbl;
    ones = '1;
    exp  = 512'd0 - (512'd1 << 257) + 512'd1;
    runOp(ones, ones, lat, dones, dbl);
    testsRun++;
    if (lat !== 5) begin testsFailed++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    testsRun++;
    if (bus.oQ !== exp) begin testsFailed++; $display("FAIL basic_q got=%h exp=%h", bus.oQ, exp); end
    testsRun++;
    if (dones !== 1 || dbl !== 0) begin testsFailed++; $display("FAIL basic_done_count got=%0d dbl=%0d exp=1", dones, dbl); end
    $display("[TB] basic: lat=%0d dones=%0d", lat, dones);
  endtask

  task automatic test_short();
    int lat, dones, dbl;
    runOp(256'h1_0000, 256'hF, lat, dones, dbl);
    testsRun++;
    if (lat !== 2) begin testsFailed++; $display("FAIL short_latency got=%0d exp=2", lat); end
    testsRun++;
    if (bus.oQ !== 512'hF_0000) begin testsFailed++; $display("FAIL short_q got=%h exp=f0000", bus.oQ); end
    $display("[TB] short: lat=%0d q=%0h", lat, bus.oQ);
    runOp(256'h1_0000, 256'h0, lat, dones, dbl);
    testsRun++;
    if (lat !== 2) begin testsFailed++; $display("FAIL zero_latency got=%0d exp=2", lat); end
    testsRun++;
    if (bus.oQ !== 512'd0) begin testsFailed++; $display("FAIL zero_q got=%h exp=0", bus.oQ); end
    $display("[TB] zero: lat=%0d q=%0h", lat, bus.oQ);
  endtask

  task automatic test_skip();
    int lat, dones, dbl;
    runOp(256'd3, 256'd1 << 128, lat, dones, dbl);
    testsRun++;
    if (lat !== 4) begin testsFailed++; $display("FAIL skip_latency got=%0d exp=4", lat); end
    testsRun++;
    if (bus.oQ !== (512'd3 << 128)) begin testsFailed++; $display("FAIL skip_q got=%h exp=3<<128", bus.oQ); end
    $display("[TB] skip: lat=%0d q=%0h", lat, bus.oQ);
  endtask

  task automatic test_back_to_back();
    int lat;
    int holdBad;
    bus.iD0 = 256'd5; bus.iD1 = 256'd7; bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    @(posedge clk); #1;
    testsRun++;
    if (bus.oDone !== 1'b1 || bus.oQ !== 512'd35) begin
      testsFailed++; $display("FAIL b2b_op1 got done=%b q=%h exp done=1 q=35", bus.oDone, bus.oQ);
    end
    bus.iD0 = 256'd2; bus.iD1 = 256'd1 << 255; bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    testsRun++;
    if (bus.oBusy !== 1'b1) begin testsFailed++; $display("FAIL b2b_no_idle got busy=%b exp=1", bus.oBusy); end
    lat = -1; holdBad = 0;
    for (int c = 2; c <= 12 && lat < 0; c++) begin
      if (bus.oQ !== 512'd35) holdBad++;
      @(posedge clk); #1;
      if (bus.oDone) lat = c;
    end
    testsRun++;
    if (holdBad !== 0) begin testsFailed++; $display("FAIL b2b_hold got=%0d bad cycles exp=0", holdBad); end
    testsRun++;
    if (lat !== 5) begin testsFailed++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
    testsRun++;
    if (bus.oQ !== (512'd1 << 256)) begin testsFailed++; $display("FAIL b2b_q got=%h exp=2^256", bus.oQ); end
    $display("[TB] back_to_back: lat=%0d q=%0h", lat, bus.oQ);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_start_busy();
    logic [255:0] ones;
    logic [511:0] exp;
    int lat, dones;
    ones = '1;
    exp  = {256'd0, ones};
    bus.iD0 = 256'd1; bus.iD1 = ones; bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    @(posedge clk); #1;
    bus.iD0 = '0; bus.iD1 = '0; bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    lat = -1; dones = 0;
    for (int c = 4; c <= 14; c++) begin
      @(posedge clk); #1;
      if (bus.oDone) begin dones++; if (lat < 0) lat = c; end
    end
    testsRun++;
    if (dones !== 1) begin testsFailed++; $display("FAIL busy_done_count got=%0d exp=1", dones); end
    testsRun++;
    if (lat !== 5) begin testsFailed++; $display("FAIL busy_latency got=%0d exp=5", lat); end
    testsRun++;
    if (bus.oQ !== exp) begin testsFailed++; $display("FAIL busy_q got=%h exp=%h", bus.oQ, exp); end
    $display("[TB] start_busy: lat=%0d dones=%0d", lat, dones);
  endtask

  task automatic test_reset_mid();
    logic [255:0] ones;
    int dones, lat, dbl;
    ones = '1;
    bus.iD0 = 256'd5; bus.iD1 = ones; bus.iStart = 1'b1;
    @(posedge clk); #1;
    bus.iStart = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    testsRun++;
    if (bus.oQ !== 512'd0) begin testsFailed++; $display("FAIL midrst_q got=%h exp=0", bus.oQ); end
    testsRun++;
    if (bus.oBusy !== 1'b0) begin testsFailed++; $display("FAIL midrst_busy got=%b exp=0", bus.oBusy); end
    dones = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.oDone) dones++;
      @(posedge clk); #1;
    end
    testsRun++;
    if (dones !== 0) begin testsFailed++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
    runOp(256'd6, 256'd7, lat, dones, dbl);
    testsRun++;
    if (lat !== 2 || bus.oQ !== 512'd42) begin
      testsFailed++; $display("FAIL midrst_recover got lat=%0d q=%h exp lat=2 q=42", lat, bus.oQ);
    end
    $display("[TB] reset_mid: recovered q=%0d", bus.oQ);
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    test_reset();
    test_basic();
    test_short();
    test_skip();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
